// File: rtl/harq_send_pkg.sv
// Shared types and helpers for the HARQ send path: FSM encoding, lane geometry,
// LLR saturation and transfer-length arithmetic.
package harq_send_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_READ  = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_COMP  = 4'b1000
    } state_t;

    localparam int LLR_IN_WIDTH = 10;
    localparam int LANES        = 16;

    // Clamp a signed combine-buffer LLR into the signed range of 'width' bits.
    function automatic logic signed [LLR_IN_WIDTH-1:0] saturate_llr(
        input logic signed [LLR_IN_WIDTH-1:0] llr,
        input int                             width
    );
        int value;
        int hi;
        int lo;
        value = int'(llr);
        hi    = (1 << (width - 1)) - 1;
        lo    = -(1 << (width - 1));
        if (value > hi) begin
            value = hi;
        end else if (value < lo) begin
            value = lo;
        end
        return LLR_IN_WIDTH'(value);
    endfunction

    function automatic logic [16:0] words_from_amount(
        input logic [15:0] amount,
        input int          addr_width
    );
        int words;
        int cap;
        words = (int'(amount) + LANES - 1) / LANES;
        cap   = 1 << addr_width;
        if (words > cap) begin
            words = cap;
        end
        return 17'(words);
    endfunction

endpackage

// File: rtl/harq_send_skid_fifo.sv
// Small synchronous FIFO holding processed words between the buffer read and
// the HARQ write port; head word is presented combinationally.
module harq_send_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PW + 1)'(1);
                2'b01:   count_reg <= count_reg - (PW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Zero when empty so the write port shows clean zeros while idle.
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/harq_send_fsm.sv
// Drains a completed ping or pong combine buffer into the HARQ write port,
// saturating each lane and zeroing lanes past the end of the transfer.
module harq_send_fsm
    import harq_send_pkg::*;
#(
    parameter int ADDR_WIDTH     = 11,
    parameter int HARQ_LLR_WIDTH = 8,
    parameter int SKID_DEPTH     = 4
) (
    input  logic                              i_core_clk,
    input  logic                              i_rx_rst,
    input  logic                              i_SENDHARQ_Data_Ping_request,
    input  logic                              i_SENDHARQ_Data_Pong_request,
    input  logic [15:0]                       i_SENDHARQ_Data_Ping_Add_Amount,
    input  logic [15:0]                       i_SENDHARQ_Data_Pong_Add_Amount,
    input  logic [3:0]                        i_SENDHARQ_Data_Ping_User_Index,
    input  logic [3:0]                        i_SENDHARQ_Data_Pong_User_Index,
    input  logic [159:0]                      i_Ping_Buffer_Read_Data,
    input  logic [159:0]                      i_Pong_Buffer_Read_Data,
    output logic [ADDR_WIDTH-1:0]             o_SENDHARQ_Data_Address,
    output logic                              o_SENDHARQ_Data_Ping_Busy,
    output logic                              o_SENDHARQ_Data_Pong_Busy,
    output logic                              o_SENDHARQ_Data_Ping_Comp,
    output logic                              o_SENDHARQ_Data_Pong_Comp,
    output logic                              o_HARQ_Wr_Valid,
    input  logic                              i_HARQ_Wr_Ready,
    output logic [LANES*HARQ_LLR_WIDTH-1:0]   o_HARQ_Wr_Data,
    output logic [ADDR_WIDTH-1:0]             o_HARQ_Wr_Addr,
    output logic [3:0]                        o_HARQ_Wr_User_Index
);

    localparam int DATA_W = LANES * HARQ_LLR_WIDTH;
    localparam int FIFO_W = 1 + ADDR_WIDTH + DATA_W;
    localparam int CNT_W  = $clog2(SKID_DEPTH) + 1;

    state_t                  state_reg, state_next;
    logic                    sel_pong_reg, sel_pong_next;
    logic                    last_pong_reg, last_pong_next;
    logic [3:0]              user_reg, user_next;
    logic [3:0]              rem_reg, rem_next;
    logic [ADDR_WIDTH-1:0]   last_addr_reg, last_addr_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic                    ping_busy_reg, ping_busy_next;
    logic                    pong_busy_reg, pong_busy_next;
    logic                    drained_reg, drained_next;

    logic                    inflight_reg;
    logic [ADDR_WIDTH-1:0]   rd_addr_reg;
    logic                    rd_last_reg;

    logic                    pick_pong;
    logic [15:0]             amount_sel;
    logic [16:0]             words_sel;
    logic                    clamped_sel;
    logic                    issue;
    logic                    last_issue;
    logic [CNT_W:0]          credit_used;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic [FIFO_W-1:0]       push_data;
    logic [FIFO_W-1:0]       pop_data;
    logic                    pop_last;
    logic [159:0]            rd_word;
    logic [DATA_W-1:0]       lane_data;

    // On a tie, serve whichever buffer was not served last.
    assign pick_pong = (i_SENDHARQ_Data_Ping_request && i_SENDHARQ_Data_Pong_request)
                       ? !last_pong_reg : i_SENDHARQ_Data_Pong_request;
    assign amount_sel  = pick_pong ? i_SENDHARQ_Data_Pong_Add_Amount : i_SENDHARQ_Data_Ping_Add_Amount;
    assign words_sel   = words_from_amount(amount_sel, ADDR_WIDTH);
    assign clamped_sel = int'(amount_sel) > (LANES << ADDR_WIDTH);

    // Reads are issued only when every outstanding word is guaranteed a FIFO slot.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};
    assign issue       = (state_reg == ST_READ) && (int'(credit_used) < SKID_DEPTH);
    assign last_issue  = issue && (addr_reg == last_addr_reg);

    assign fifo_pop = !fifo_empty && i_HARQ_Wr_Ready;
    assign pop_last = pop_data[FIFO_W-1];

    always_comb begin
        state_next     = state_reg;
        sel_pong_next  = sel_pong_reg;
        last_pong_next = last_pong_reg;
        user_next      = user_reg;
        rem_next       = rem_reg;
        last_addr_next = last_addr_reg;
        addr_next      = addr_reg;
        ping_busy_next = ping_busy_reg;
        pong_busy_next = pong_busy_reg;
        drained_next   = drained_reg | (fifo_pop & pop_last);
        case (state_reg)
            ST_IDLE: begin
                addr_next    = '0;
                drained_next = 1'b0;
                if (i_SENDHARQ_Data_Ping_request || i_SENDHARQ_Data_Pong_request) begin
                    sel_pong_next  = pick_pong;
                    user_next      = pick_pong ? i_SENDHARQ_Data_Pong_User_Index
                                               : i_SENDHARQ_Data_Ping_User_Index;
                    rem_next       = clamped_sel ? 4'd0 : amount_sel[3:0];
                    last_addr_next = ADDR_WIDTH'(words_sel - 17'd1);
                    ping_busy_next = !pick_pong;
                    pong_busy_next = pick_pong;
                    state_next     = (amount_sel == 16'd0) ? ST_COMP : ST_READ;
                end
            end
            ST_READ: begin
                if (last_issue) begin
                    state_next = ST_DRAIN;
                end else if (issue) begin
                    addr_next = addr_reg + ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                if (!inflight_reg && fifo_empty && drained_reg) begin
                    state_next = ST_COMP;
                end
            end
            ST_COMP: begin
                ping_busy_next = 1'b0;
                pong_busy_next = 1'b0;
                last_pong_next = sel_pong_reg;
                addr_next      = '0;
                state_next     = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            state_reg     <= ST_IDLE;
            sel_pong_reg  <= 1'b0;
            last_pong_reg <= 1'b1;
            user_reg      <= '0;
            rem_reg       <= '0;
            last_addr_reg <= '0;
            addr_reg      <= '0;
            ping_busy_reg <= 1'b0;
            pong_busy_reg <= 1'b0;
            drained_reg   <= 1'b0;
            inflight_reg  <= 1'b0;
            rd_addr_reg   <= '0;
            rd_last_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sel_pong_reg  <= sel_pong_next;
            last_pong_reg <= last_pong_next;
            user_reg      <= user_next;
            rem_reg       <= rem_next;
            last_addr_reg <= last_addr_next;
            addr_reg      <= addr_next;
            ping_busy_reg <= ping_busy_next;
            pong_busy_reg <= pong_busy_next;
            drained_reg   <= drained_next;
            inflight_reg  <= issue;
            rd_addr_reg   <= addr_reg;
            rd_last_reg   <= last_issue;
        end
    end

    assign rd_word = sel_pong_reg ? i_Pong_Buffer_Read_Data : i_Ping_Buffer_Read_Data;

    // Lanes at or beyond the remainder of the final word carry no real LLRs.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic masked;
            assign masked = rd_last_reg && (rem_reg != 4'd0) && (4'(gi) >= rem_reg);
            assign lane_data[gi*HARQ_LLR_WIDTH +: HARQ_LLR_WIDTH] = masked ? '0 :
                HARQ_LLR_WIDTH'(saturate_llr(rd_word[gi*LLR_IN_WIDTH +: LLR_IN_WIDTH], HARQ_LLR_WIDTH));
        end
    endgenerate

    assign push_data = {rd_last_reg, rd_addr_reg, lane_data};

    harq_send_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (FIFO_W)
    ) u_skid_fifo (
        .clk       (i_core_clk),
        .srst      (i_rx_rst),
        .push      (inflight_reg),
        .push_data (push_data),
        .pop       (fifo_pop),
        .pop_data  (pop_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign o_SENDHARQ_Data_Address   = addr_reg;
    assign o_SENDHARQ_Data_Ping_Busy = ping_busy_reg;
    assign o_SENDHARQ_Data_Pong_Busy = pong_busy_reg;
    assign o_SENDHARQ_Data_Ping_Comp = (state_reg == ST_COMP) && !sel_pong_reg;
    assign o_SENDHARQ_Data_Pong_Comp = (state_reg == ST_COMP) && sel_pong_reg;
    assign o_HARQ_Wr_Valid           = !fifo_empty;
    assign o_HARQ_Wr_Data            = pop_data[DATA_W-1:0];
    assign o_HARQ_Wr_Addr            = pop_data[DATA_W +: ADDR_WIDTH];
    assign o_HARQ_Wr_User_Index      = user_reg;

endmodule

// File: tb/tb_harq_send_fsm.sv
// Directed bench for harq_send_fsm: buffer SRAM model, combine-side request
// model, and a word-by-word scoreboard on the HARQ write port.
module tb_harq_send_fsm;

    localparam int AW = 11;

    logic           clk = 1'b0;
    logic           rst;
    logic           ping_req, pong_req;
    logic [15:0]    ping_amt, pong_amt;
    logic [3:0]     ping_user, pong_user;
    logic [159:0]   ping_q, pong_q;
    logic [AW-1:0]  rd_addr;
    logic           ping_busy, pong_busy, ping_comp, pong_comp;
    logic           wr_valid, wr_ready;
    logic [127:0]   wr_data;
    logic [AW-1:0]  wr_addr;
    logic [3:0]     wr_user;

    always #5 clk = ~clk;

    harq_send_fsm dut (
        .i_core_clk                      (clk),
        .i_rx_rst                        (rst),
        .i_SENDHARQ_Data_Ping_request    (ping_req),
        .i_SENDHARQ_Data_Pong_request    (pong_req),
        .i_SENDHARQ_Data_Ping_Add_Amount (ping_amt),
        .i_SENDHARQ_Data_Pong_Add_Amount (pong_amt),
        .i_SENDHARQ_Data_Ping_User_Index (ping_user),
        .i_SENDHARQ_Data_Pong_User_Index (pong_user),
        .i_Ping_Buffer_Read_Data         (ping_q),
        .i_Pong_Buffer_Read_Data         (pong_q),
        .o_SENDHARQ_Data_Address         (rd_addr),
        .o_SENDHARQ_Data_Ping_Busy       (ping_busy),
        .o_SENDHARQ_Data_Pong_Busy       (pong_busy),
        .o_SENDHARQ_Data_Ping_Comp       (ping_comp),
        .o_SENDHARQ_Data_Pong_Comp       (pong_comp),
        .o_HARQ_Wr_Valid                 (wr_valid),
        .i_HARQ_Wr_Ready                 (wr_ready),
        .o_HARQ_Wr_Data                  (wr_data),
        .o_HARQ_Wr_Addr                  (wr_addr),
        .o_HARQ_Wr_User_Index            (wr_user)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Source LLRs; word 0 lanes 0..4 hold the saturation corner values.
    function automatic logic signed [9:0] src_val(input bit pong, input int addr, input int lane);
        int v;
        if (addr == 0 && lane < 5) begin
            case (lane)
                0:       v = 200;
                1:       v = -300;
                2:       v = 127;
                3:       v = -128;
                default: v = -5;
            endcase
        end else begin
            v = ((addr * 16 + lane) * 37 + (pong ? 100 : 0)) % 1024;
            if (v >= 512) v = v - 1024;
        end
        return 10'(v);
    endfunction

    function automatic logic [159:0] mk_word(input bit pong, input int addr);
        logic [159:0] w;
        for (int l = 0; l < 16; l++) w[l*10 +: 10] = src_val(pong, addr, l);
        return w;
    endfunction

    function automatic int exp_words(input int amount);
        int n;
        n = (amount + 15) / 16;
        return (n > 2048) ? 2048 : n;
    endfunction

    function automatic logic [127:0] exp_word(input bit pong, input int idx, input int amount);
        logic [127:0] w;
        int s;
        for (int l = 0; l < 16; l++) begin
            s = int'(src_val(pong, idx, l));
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            if (idx == exp_words(amount) - 1 && amount % 16 != 0 && amount <= 32768 && l >= amount % 16)
                s = 0;
            w[l*8 +: 8] = 8'(s);
        end
        return w;
    endfunction

    always @(posedge clk) begin
        ping_q <= mk_word(1'b0, int'(rd_addr));
        pong_q <= mk_word(1'b1, int'(rd_addr));
    end

    typedef struct {
        bit         pong;
        int         amount;
        logic [3:0] user;
    } xfer_t;

    xfer_t        exp_q[$];
    int           exp_idx   = 0;
    int           comp_cnt  = 0;
    bit           mon_en    = 1'b0;
    bit           hold_pend = 1'b0;
    logic [127:0] hold_data;
    logic [AW-1:0] hold_addr;
    logic [127:0] word0, word2;
    int           rdy_mode  = 0;
    int           rdy_cyc   = 0;

    // Scoreboard plus combine-side behaviour (drop request after Comp).
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (hold_pend) begin
                    chk("hold_valid", wr_valid, 1'b1);
                    chk("hold_data", wr_data, hold_data);
                    chk("hold_addr", wr_addr, hold_addr);
                end
                hold_pend = wr_valid && !wr_ready;
                hold_data = wr_data;
                hold_addr = wr_addr;
                if (wr_valid && wr_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_valid", wr_valid, 1'b0);
                    end else begin
                        chk("wr_addr", wr_addr, exp_idx);
                        chk("wr_user", wr_user, exp_q[0].user);
                        chk("wr_data", wr_data, exp_word(exp_q[0].pong, exp_idx, exp_q[0].amount));
                        if (exp_idx == 0) word0 = wr_data;
                        if (exp_idx == 2) word2 = wr_data;
                        exp_idx++;
                    end
                end
                if (ping_comp || pong_comp) begin
                    comp_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("spurious_comp", ping_comp | pong_comp, 1'b0);
                    end else begin
                        chk("comp_buf", pong_comp, exp_q[0].pong);
                        chk("word_count", exp_idx, exp_words(exp_q[0].amount));
                        $display("xfer %s user=%0d amount=%0d words=%0d",
                                 exp_q[0].pong ? "pong" : "ping", exp_q[0].user, exp_q[0].amount, exp_idx);
                        void'(exp_q.pop_front());
                        exp_idx = 0;
                    end
                    if (ping_comp) ping_req = 1'b0;
                    if (pong_comp) pong_req = 1'b0;
                end
            end
        end
    end

    // Ready pattern 1: 1010 1010 then low for 10 cycles, then high.
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                wr_ready = 1'b1;
            end else begin
                if (rdy_cyc < 8)       wr_ready = (rdy_cyc % 2 == 0);
                else if (rdy_cyc < 18) wr_ready = 1'b0;
                else                   wr_ready = 1'b1;
                rdy_cyc++;
            end
        end
    end

    task automatic start_req(input bit pong, input int amount, input logic [3:0] user);
        xfer_t x;
        x.pong = pong; x.amount = amount; x.user = user;
        exp_q.push_back(x);
        if (pong) begin
            pong_amt = 16'(amount); pong_user = user; pong_req = 1'b1;
        end else begin
            ping_amt = 16'(amount); ping_user = user; ping_req = 1'b1;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_in_time", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b0; rst = 1'b1; ping_req = 1'b0; pong_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete(); exp_idx = 0; hold_pend = 1'b0; mon_en = 1'b1;
    endtask

    initial begin
        int cyc;
        int busy_cnt;
        int comp0;
        bit valid_seen;

        rst = 1'b1; ping_req = 1'b0; pong_req = 1'b0;
        ping_amt = '0; pong_amt = '0; ping_user = '0; pong_user = '0;
        do_reset();
        @(negedge clk);
        chk("rst_valid", wr_valid, 1'b0);
        chk("rst_ping_busy", ping_busy, 1'b0);
        chk("rst_pong_busy", pong_busy, 1'b0);
        chk("rst_comp", {ping_comp, pong_comp}, 2'b00);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_user", wr_user, 0);

        // Single ping transfer: latency, saturation corners, tail masking.
        @(posedge clk); #1;
        comp0 = comp_cnt;
        start_req(1'b0, 40, 4'd3);
        cyc = 0;
        while (!wr_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("busy_before_accept", ping_busy, 1'b0);
            if (cyc == 2) chk("busy_after_accept", ping_busy, 1'b1);
        end
        chk("first_valid_latency", cyc, 4);
        wait_done(100);
        @(negedge clk);
        chk("ping_busy_cleared", ping_busy, 1'b0);
        chk("ping_comp_count", comp_cnt - comp0, 1);
        chk("sat_200", word0[7:0], 8'h7F);
        chk("sat_m300", word0[15:8], 8'h80);
        chk("sat_127", word0[23:16], 8'h7F);
        chk("sat_m128", word0[31:24], 8'h80);
        chk("sat_m5", word0[39:32], 8'hFB);
        chk("tail_lanes_zero", word2[127:64], 64'h0);

        // Tie after reset: ping first, then pong.
        do_reset();
        @(posedge clk); #1;
        start_req(1'b0, 40, 4'd3);
        start_req(1'b1, 20, 4'd9);
        wait_done(200);
        // Single ping makes ping the last served, so the next tie goes to pong.
        @(posedge clk); #1;
        start_req(1'b0, 16, 4'd4);
        wait_done(100);
        @(posedge clk); #1;
        start_req(1'b1, 33, 4'd7);
        start_req(1'b0, 17, 4'd2);
        wait_done(200);

        // Backpressure: toggling ready, then a long stall.
        @(posedge clk); #1;
        rdy_cyc = 0; rdy_mode = 1;
        start_req(1'b1, 64, 4'd12);
        wait_done(200);
        rdy_mode = 0;

        // Zero-length transfer.
        @(posedge clk); #1;
        comp0 = comp_cnt;
        start_req(1'b0, 0, 4'd1);
        busy_cnt = 0; valid_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            busy_cnt += int'(ping_busy);
            valid_seen |= wr_valid;
        end
        chk("zero_busy_cycles", busy_cnt, 1);
        chk("zero_no_valid", valid_seen, 1'b0);
        chk("zero_comp_count", comp_cnt - comp0, 1);
        chk("zero_done", exp_q.size(), 0);

        // Oversized transfer clamps to 2048 words.
        @(posedge clk); #1;
        start_req(1'b1, 40000, 4'd8);
        wait_done(3000);

        // Reset in the middle of a 256-word read.
        @(posedge clk); #1;
        comp0 = comp_cnt;
        start_req(1'b0, 4096, 4'd5);
        repeat (30) @(negedge clk);
        @(posedge clk); #1;
        mon_en = 1'b0; rst = 1'b1; ping_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", ping_busy, 1'b0);
        chk("mid_rst_valid", wr_valid, 1'b0);
        chk("mid_rst_rd_addr", rd_addr, 0);
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_no_comp", {ping_comp, pong_comp}, 2'b00);
            @(negedge clk);
        end
        exp_q.delete(); exp_idx = 0; hold_pend = 1'b0; mon_en = 1'b1;
        chk("mid_rst_comp_count", comp_cnt - comp0, 0);
        @(posedge clk); #1;
        start_req(1'b0, 40, 4'd6);
        wait_done(100);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/harq_send_fsm.md
Name: harq_send_fsm

Overview:
- Drains completed combine buffers (ping/pong, 16 LLRs x 10 bit per word) into the HARQ write port.
- Counterpart of the combine FSM on the SENDHARQ request/busy/comp interface: it accepts ping/pong requests, generates the buffer read address and consumes the 160-bit read data.
- Saturates each lane to HARQ_LLR_WIDTH, zeroes lanes past the transfer length, and emits words under valid/ready backpressure.

Parameters:
- ADDR_WIDTH, 11, combine buffer word-address width; max 2^ADDR_WIDTH words per transfer.
- HARQ_LLR_WIDTH, 8, stored signed LLR width per lane after saturation.
- SKID_DEPTH, 4, output FIFO depth in words (power of 2, >=3).

Ports:
- i_core_clk  in  1  core clock; all logic on rising edge.
- i_rx_rst  in  1  reset: synchronous, active-high.
- i_SENDHARQ_Data_Ping_request  in  1  level; high until Ping_Comp seen.
- i_SENDHARQ_Data_Pong_request  in  1  level; high until Pong_Comp seen.
- i_SENDHARQ_Data_Ping_Add_Amount  in  16  LLR count in ping buffer.
- i_SENDHARQ_Data_Pong_Add_Amount  in  16  LLR count in pong buffer.
- i_SENDHARQ_Data_Ping_User_Index  in  4  user owning ping data.
- i_SENDHARQ_Data_Pong_User_Index  in  4  user owning pong data.
- i_Ping_Buffer_Read_Data  in  160  ping SRAM q, 1-cycle registered read.
- i_Pong_Buffer_Read_Data  in  160  pong SRAM q, 1-cycle registered read.
- o_SENDHARQ_Data_Address  out  ADDR_WIDTH  read address to the active buffer.
- o_SENDHARQ_Data_Ping_Busy  out  1  ping transfer in progress.
- o_SENDHARQ_Data_Pong_Busy  out  1  pong transfer in progress.
- o_SENDHARQ_Data_Ping_Comp  out  1  one-cycle pulse, ping drained.
- o_SENDHARQ_Data_Pong_Comp  out  1  one-cycle pulse, pong drained.
- o_HARQ_Wr_Valid  out  1  output word valid.
- i_HARQ_Wr_Ready  in  1  sink accepts the word when valid and ready are both high.
- o_HARQ_Wr_Data  out  16*HARQ_LLR_WIDTH  saturated LLRs, lane i at [i*W+W-1:i*W].
- o_HARQ_Wr_Addr  out  ADDR_WIDTH  word offset within the user's HARQ region.
- o_HARQ_Wr_User_Index  out  4  user index for the word.

Behaviour:
- Reset values: all outputs 0; FIFO empty; last_served = pong, so ping wins the first tie.
- States:
  - IDLE: requests are sampled only here.
    - Only ping request -> select ping; only pong -> select pong.
    - Both requests -> select the one not equal to last_served.
    - On leaving, latch amount and user, and set the selected Busy (registered, high from the cycle after acceptance).
    - num_words = ceil(amount/16), clamped to 2^ADDR_WIDTH.
    - Next state is READ, or COMP if amount==0.
  - READ:
    - Issue one read per cycle when fifo_count + inflight < SKID_DEPTH.
    - The address counter increments on issue.
    - When the last address is issued -> DRAIN.
  - DRAIN: wait until inflight==0 and the FIFO is empty (all words accepted) -> COMP.
  - COMP: one cycle.
    - Pulse the selected Comp and clear its Busy.
    - last_served = selected.
    - Next state IDLE.
- o_SENDHARQ_Data_Address holds the issue address; it is 0 in IDLE.
- Read data path:
  - Data is valid the cycle after issue, from the selected buffer.
  - The word is tagged with its address and a last flag, then pushed into the FIFO.
  - No FIFO overflow is possible under the credit rule.
- Lane processing (combinational, before the FIFO push):
  - Each 10-bit signed lane is saturated to [-2^(W-1), 2^(W-1)-1].
  - Example for W=8: 200 -> 127, -300 -> -128, -5 -> -5.
  - On the last word, lanes with index >= (amount mod 16) are forced to 0, unless amount mod 16 == 0.
- Output:
  - Valid = FIFO non-empty; data is held stable while valid and not ready.
  - Throughput is 1 word/cycle with ready held high.
  - First output valid is 3 cycles after request sampling in IDLE (IDLE->READ, issue, push).
- A request for the busy buffer is ignored until COMP. The combine side drops its request the cycle after Comp, so IDLE never re-accepts the same transfer.
- Reset mid-transfer:
  - Return to IDLE, flush the FIFO, drop inflight data.
  - Busy and Valid go low next cycle; no Comp pulse.

Decomposition:
- Shared package holds:
  - State encoding (one-hot: IDLE, READ, DRAIN, COMP).
  - LLR_IN_WIDTH=10 and LANES=16.
  - Saturate function (10 -> W signed).
  - Words-from-amount function with clamp.
- One sub-module: harq_send_skid_fifo, a synchronous FIFO of SKID_DEPTH words carrying {last, addr, data} with count output.

Test Plan:
- Ping request, amount=40, ready=1 -> Ping_Busy high, 3 words at addr 0..2; word 2 lanes 8..15 = 0; one Ping_Comp; Busy low after Comp.
- Ping and pong requests asserted in the same cycle after reset -> ping served first, then pong; user indices tagged correctly; alternation continues on the next tie.
- Lane values 200, -300, 127, -128, -5 -> output 127, -128, 127, -128, -5.
- amount=64 with ready toggling 1010 and then held low 10 cycles -> no data loss or duplication, words in order, FIFO never exceeds 4, data stable while stalled.
- amount=0 -> Busy for 1 cycle, Comp pulse, no o_HARQ_Wr_Valid. amount=40000 -> exactly 2048 words.
- Reset asserted during READ of a 256-word transfer -> next cycle: IDLE, Busy=0, Valid=0, no Comp; a new request afterwards completes normally from addr 0.
